// File: rtl/lampFPU_pkg.sv
// lampFPU_pkg: shared constants and types for the LAMP float square-root control block.
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_DW   = 16;
  localparam int unsigned LAMP_FLOAT_E_DW = 8;
  localparam int unsigned LAMP_FLOAT_F_DW = 7;

  localparam int          BIAS        = 127;
  localparam int unsigned CORE_RES_DW = 2 * (1 + LAMP_FLOAT_F_DW);
  localparam int unsigned EXP_W       = LAMP_FLOAT_E_DW + 2;

  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_QNAN = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_INF  = 16'h7F80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ROUND,
    ST_DONE
  } sqrt_state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } op_class_t;

  // Operand class from the raw exponent and fraction fields.
  function automatic op_class_t classify(input logic [LAMP_FLOAT_E_DW-1:0] e,
                                         input logic [LAMP_FLOAT_F_DW-1:0] f);
    if (e == '0)      return (f == '0) ? CLS_ZERO : CLS_DENORM;
    else if (e == '1) return (f == '0) ? CLS_INF  : CLS_NAN;
    else              return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_sqrt_lzc.sv
// fp_sqrt_lzc: 7-bit combinational leading-zero counter used to normalise
// denormal operands. Only present when FP_SQRT_DENORM_EN is defined.
`ifdef FP_SQRT_DENORM_EN
module fp_sqrt_lzc (
  input  logic [6:0] val_i,
  output logic [2:0] lz_o
);

  // Highest set bit wins; an all-zero input reports 7.
  always_comb begin
    lz_o = 3'd7;
    for (int unsigned i = 0; i < 7; i++) begin
      if (val_i[i]) lz_o = 3'(6 - i);
    end
  end

endmodule
`endif

// File: rtl/fp_sqrt_ctrl.sv
// fp_sqrt_ctrl: unpack/classify a LAMP float operand, issue one job to the
// iterative significand sqrt core, then normalise, round (RNE) and pack.
// Optional feature: FP_SQRT_DENORM_EN (normalise denormal operands instead of
// flushing them to signed zero).
module fp_sqrt_ctrl
  import lampFPU_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [15:0]            op_i,
  input  logic                   invSqrt_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [15:0]            res_o,
  output logic                   invalid_o,
  output logic                   divzero_o,
  output logic                   core_doSqrt_o,
  output logic [7:0]             core_s_o,
  output logic                   core_odd_o,
  output logic                   core_inv_o,
  output logic                   core_spec_o,
  input  logic                   core_valid_i,
  input  logic [CORE_RES_DW-1:0] core_res_i
);

  sqrt_state_t             state_q, state_d;
  logic                    inv_q, inv_d;
  logic [7:0]              s_q, s_d;
  logic                    odd_q, odd_d;
  logic signed [EXP_W-1:0] k_q, k_d;
  logic                    spec_q, spec_d;
  logic [15:0]             sres_q, sres_d;
  logic                    sinv_q, sinv_d;
  logic                    sdz_q, sdz_d;
  logic [CORE_RES_DW-1:0]  r_q, r_d;
  logic [15:0]             res_q, res_d;
  logic                    invalid_q, invalid_d;
  logic                    divzero_q, divzero_d;

  logic                    fe_sign;
  logic [7:0]              fe_exp;
  logic [6:0]              fe_frac;
  op_class_t               fe_cls;
  logic                    fe_zero;
  logic                    fe_spec;
  logic [15:0]             fe_sres;
  logic                    fe_invalid;
  logic                    fe_dz;
  logic [7:0]              fe_s;
  logic signed [EXP_W-1:0] fe_e;

  logic [CORE_RES_DW-1:0]  rnd_r;
  logic signed [EXP_W-1:0] rnd_e;
  logic                    rnd_inc;
  logic [6:0]              rnd_frac;
  logic [15:0]             rnd_res;

  assign fe_sign = op_i[15];
  assign fe_exp  = op_i[14:7];
  assign fe_frac = op_i[6:0];

`ifdef FP_SQRT_DENORM_EN
  logic [2:0] fe_lz;

  fp_sqrt_lzc u_lzc (
    .val_i (fe_frac),
    .lz_o  (fe_lz)
  );
`endif

  // Operand unpack: classify, split exponent, build special-case result.
  always_comb begin
    fe_cls     = classify(fe_exp, fe_frac);
    fe_s       = {1'b1, fe_frac};
    fe_e       = $signed({2'b00, fe_exp}) - EXP_W'(BIAS);
`ifdef FP_SQRT_DENORM_EN
    // Denormal: shift the leading one into the hidden position, E = -126-(lz+1).
    if (fe_cls == CLS_DENORM) begin
      fe_s = {1'b0, fe_frac} << (fe_lz + 3'd1);
      fe_e = EXP_W'(-127) - $signed({7'd0, fe_lz});
    end
    fe_zero = (fe_cls == CLS_ZERO);
`else
    fe_zero = (fe_cls == CLS_ZERO) || (fe_cls == CLS_DENORM);
`endif
    fe_spec    = 1'b1;
    fe_sres    = '0;
    fe_invalid = 1'b0;
    fe_dz      = 1'b0;
    if (fe_cls == CLS_NAN) begin
      fe_sres    = LAMP_QNAN;
      fe_invalid = 1'b1;
    end else if (fe_zero) begin
      fe_sres = invSqrt_i ? {fe_sign, LAMP_INF[14:0]} : {fe_sign, 15'd0};
      fe_dz   = invSqrt_i;
    end else if (fe_sign) begin
      fe_sres    = LAMP_QNAN;
      fe_invalid = 1'b1;
    end else if (fe_cls == CLS_INF) begin
      fe_sres = invSqrt_i ? 16'h0000 : LAMP_INF;
    end else begin
      fe_spec = 1'b0;
    end
    if (fe_spec) begin
      fe_s = '0;
      fe_e = '0;
    end
  end

  // Normalise the core result, apply RNE on bits [7:0], form the packed result.
  always_comb begin
    rnd_r = r_q;
    rnd_e = inv_q ? -k_q : k_q;
    if (!rnd_r[15]) begin
      rnd_r = rnd_r << 1;
      rnd_e = rnd_e - EXP_W'(1);
    end
    rnd_inc = rnd_r[7] & ((|rnd_r[6:0]) | rnd_r[8]);
    // Hidden bit is 1 after normalisation, so a carry out of the 7-bit
    // fraction wraps it to zero and bumps the exponent.
    rnd_frac = rnd_r[14:8] + {6'd0, rnd_inc};
    if (rnd_inc && (&rnd_r[14:8])) rnd_e = rnd_e + EXP_W'(1);
    rnd_res = {1'b0, 8'(rnd_e + EXP_W'(BIAS)), rnd_frac};
  end

  // FSM next state, datapath captures and handshake outputs.
  always_comb begin
    state_d       = state_q;
    inv_d         = inv_q;
    s_d           = s_q;
    odd_d         = odd_q;
    k_d           = k_q;
    spec_d        = spec_q;
    sres_d        = sres_q;
    sinv_d        = sinv_q;
    sdz_d         = sdz_q;
    r_d           = r_q;
    res_d         = res_q;
    invalid_d     = invalid_q;
    divzero_d     = divzero_q;
    ready_o       = 1'b0;
    valid_o       = 1'b0;
    core_doSqrt_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          inv_d   = invSqrt_i;
          s_d     = fe_s;
          odd_d   = fe_e[0];
          k_d     = fe_e >>> 1;
          spec_d  = fe_spec;
          sres_d  = fe_sres;
          sinv_d  = fe_invalid;
          sdz_d   = fe_dz;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_doSqrt_o = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (spec_q) begin
          state_d = ST_ROUND;
        end else if (core_valid_i) begin
          r_d     = core_res_i;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (spec_q) begin
          res_d     = sres_q;
          invalid_d = sinv_q;
          divzero_d = sdz_q;
        end else begin
          res_d     = rnd_res;
          invalid_d = 1'b0;
          divzero_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      inv_q     <= 1'b0;
      s_q       <= '0;
      odd_q     <= 1'b0;
      k_q       <= '0;
      spec_q    <= 1'b0;
      sres_q    <= '0;
      sinv_q    <= 1'b0;
      sdz_q     <= 1'b0;
      r_q       <= '0;
      res_q     <= '0;
      invalid_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inv_q     <= inv_d;
      s_q       <= s_d;
      odd_q     <= odd_d;
      k_q       <= k_d;
      spec_q    <= spec_d;
      sres_q    <= sres_d;
      sinv_q    <= sinv_d;
      sdz_q     <= sdz_d;
      r_q       <= r_d;
      res_q     <= res_d;
      invalid_q <= invalid_d;
      divzero_q <= divzero_d;
    end
  end

  assign res_o       = res_q;
  assign invalid_o   = invalid_q;
  assign divzero_o   = divzero_q;
  assign core_s_o    = s_q;
  assign core_odd_o  = odd_q;
  assign core_inv_o  = inv_q;
  assign core_spec_o = spec_q;

endmodule
